// File: rtl/debug_reg_dumper.sv
// Debug register dumper: walks the register bank's debug read port, snapshots
// each word and streams it MSB byte first over a valid/ready byte interface.
module debug_reg_dumper #(
  parameter int BITS_REGS = 5,
  parameter int BITS_SIZE = 32,
  parameter int REG_SIZE  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [BITS_SIZE-1:0] i_reg_data,
  input  logic                 i_tx_ready,
  output logic [BITS_REGS-1:0] o_addr_regs,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NBYTES = BITS_SIZE / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [BITS_REGS-1:0] LAST_REG  = BITS_REGS'(REG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t               state, state_n;
  logic [BITS_SIZE-1:0] shift, shift_n;
  logic [BITS_REGS-1:0] reg_idx, reg_idx_n;
  logic [CNT_W-1:0]     byte_cnt, byte_cnt_n;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      shift    <= '0;
      reg_idx  <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      reg_idx  <= reg_idx_n;
      byte_cnt <= byte_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    reg_idx_n  = reg_idx;
    byte_cnt_n = byte_cnt;
    case (state)
      IDLE: begin
        if (i_start) begin
          reg_idx_n = '0;
          state_n   = READ;
        end
      end
      READ: begin
        // Address has been stable for a full cycle, so the word is captured once here.
        shift_n    = i_reg_data;
        byte_cnt_n = '0;
        state_n    = SEND;
      end
      SEND: begin
        if (i_tx_ready) begin
          if (byte_cnt != LAST_BYTE) begin
            shift_n    = shift << 8;
            byte_cnt_n = byte_cnt + CNT_W'(1);
          end else if (reg_idx != LAST_REG) begin
            reg_idx_n = reg_idx + BITS_REGS'(1);
            state_n   = READ;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign o_addr_regs = reg_idx;
  assign o_tx_valid  = (state == SEND);
  assign o_tx_data   = (state == SEND) ? shift[BITS_SIZE-1 -: 8] : '0;
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);

endmodule
